// File: rtl/audio_level_meter.sv
// audio_level_meter: windowed-peak mic level meter with a thermometer LED bar and a
// two-digit multiplexed active-low 7-seg readout. Define PEAK_HOLD_EN for peak-hold display.
module audio_level_meter #(
    parameter int SAMPLE_W     = 12,
    parameter int LEVELS       = 16,
    parameter int BASE         = 2048,
    parameter int STEP_LOG2    = 7,
    parameter int WINDOW       = 10000,
    parameter int SCAN_DIV     = 131232,
    parameter int HOLD_WINDOWS = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      sample_valid,
    input  logic [SAMPLE_W-1:0]       sample,
    output logic [$clog2(LEVELS)-1:0] level,
    output logic                      level_valid,
    output logic [LEVELS-1:0]         led,
    output logic [6:0]                seg,
    output logic [3:0]                an,
    output logic                      dp
);
    localparam int LW      = $clog2(LEVELS);
    localparam int CNT_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MAX_LVL = LEVELS - 1;
    localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WINDOW - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SAMPLE_W:0] BASE_X    = (SAMPLE_W+1)'(BASE);
    localparam logic [SAMPLE_W:0] MAX_X     = (SAMPLE_W+1)'(MAX_LVL);

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    function automatic logic [LEVELS-1:0] therm(input logic [LW-1:0] l);
        logic [LEVELS-1:0] t;
        for (int i = 0; i < LEVELS; i++) begin
            t[i] = (i <= int'(l));
        end
        return t;
    endfunction

    logic [CNT_W-1:0]    win_cnt_r;
    logic [SAMPLE_W-1:0] run_max_r;
    logic [LW-1:0]       level_r;
    logic                level_valid_r;
    logic [LEVELS-1:0]   led_r;
    logic [SCAN_W-1:0]   scan_cnt_r;
    logic                sel_r;
    logic [6:0]          seg_r;
    logic [3:0]          an_r;

    logic [SAMPLE_W-1:0] peak_s;
    logic [SAMPLE_W:0]   peak_x_s;
    logic [SAMPLE_W:0]   diff_s;
    logic [SAMPLE_W:0]   quo_s;
    logic [LW-1:0]       lvl_s;
    logic                close_s;
    logic [LEVELS-1:0]   led_nx_s;
    logic [LW-1:0]       disp_s;
    logic                scan_wrap_s;
    logic                sel_nx_s;
    logic [3:0]          tens_s;
    logic [3:0]          ones_s;
    logic [6:0]          seg_nx_s;
    logic [3:0]          an_nx_s;

    // Running peak including the current sample, and its quantised level (no wrap below BASE).
    always_comb begin
        peak_s   = run_max_r;
        peak_x_s = '0;
        diff_s   = '0;
        quo_s    = '0;
        lvl_s    = '0;
        close_s  = sample_valid && (win_cnt_r == WIN_LAST);
        if (sample > run_max_r) begin
            peak_s = sample;
        end else begin
            peak_s = run_max_r;
        end
        peak_x_s = {1'b0, peak_s};
        if (peak_x_s <= BASE_X) begin
            diff_s = '0;
        end else begin
            diff_s = peak_x_s - BASE_X;
        end
        quo_s = diff_s >> STEP_LOG2;
        if (quo_s > MAX_X) begin
            lvl_s = LW'(MAX_LVL);
        end else begin
            lvl_s = quo_s[LW-1:0];
        end
    end

`ifdef PEAK_HOLD_EN
    localparam int HT_W = $clog2(HOLD_WINDOWS + 1);
    localparam logic [HT_W-1:0] HT_MAX = HT_W'(HOLD_WINDOWS);

    function automatic logic [LEVELS-1:0] onehot(input logic [LW-1:0] l);
        logic [LEVELS-1:0] t;
        for (int i = 0; i < LEVELS; i++) begin
            t[i] = (i == int'(l));
        end
        return t;
    endfunction

    logic [LW-1:0]   hold_r;
    logic [HT_W-1:0] hold_tmr_r;
    logic [LW-1:0]   hold_nx_s;
    logic [HT_W-1:0] hold_tmr_nx_s;

    // Hold tracks new maxima at once, then decays one step per window after the hold time.
    always_comb begin
        hold_nx_s     = hold_r;
        hold_tmr_nx_s = hold_tmr_r;
        if (lvl_s >= hold_r) begin
            hold_nx_s     = lvl_s;
            hold_tmr_nx_s = '0;
        end else if (hold_tmr_r < HT_MAX) begin
            hold_nx_s     = hold_r;
            hold_tmr_nx_s = hold_tmr_r + HT_W'(1);
        end else begin
            hold_nx_s     = hold_r - LW'(1);
            hold_tmr_nx_s = hold_tmr_r;
        end
        led_nx_s = therm(lvl_s) | onehot(hold_nx_s);
        disp_s   = hold_r;
    end

    // Hold register and its window timer, advanced once per closed window.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_r     <= '0;
            hold_tmr_r <= '0;
        end else if (close_s) begin
            hold_r     <= hold_nx_s;
            hold_tmr_r <= hold_tmr_nx_s;
        end else begin
            hold_r     <= hold_r;
            hold_tmr_r <= hold_tmr_r;
        end
    end
`else
    // Without peak hold the bar and readout both follow the current level.
    always_comb begin
        led_nx_s = therm(lvl_s);
        disp_s   = level_r;
    end
`endif

    // Window accumulator: sample count and running max, cleared when a window closes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            win_cnt_r <= '0;
            run_max_r <= '0;
        end else if (close_s) begin
            win_cnt_r <= '0;
            run_max_r <= '0;
        end else if (sample_valid) begin
            win_cnt_r <= win_cnt_r + CNT_W'(1);
            run_max_r <= peak_s;
        end else begin
            win_cnt_r <= win_cnt_r;
            run_max_r <= run_max_r;
        end
    end

    // Level, LED bar and one-cycle update strobe, registered the cycle after window close.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            level_r       <= '0;
            level_valid_r <= 1'b0;
            led_r         <= LEVELS'(1);
        end else begin
            level_valid_r <= close_s;
            if (close_s) begin
                level_r <= lvl_s;
                led_r   <= led_nx_s;
            end else begin
                level_r <= level_r;
                led_r   <= led_r;
            end
        end
    end

    // Next slot contents; tens slot blanks entirely when the tens digit is zero.
    always_comb begin
        scan_wrap_s = (scan_cnt_r == SCAN_LAST);
        sel_nx_s    = ~sel_r;
        tens_s      = 4'(7'(disp_s) / 7'd10);
        ones_s      = 4'(7'(disp_s) % 7'd10);
        seg_nx_s    = 7'b1111111;
        an_nx_s     = 4'b1111;
        if (sel_nx_s == 1'b0) begin
            an_nx_s  = 4'b1110;
            seg_nx_s = seg_encode(ones_s);
        end else if (tens_s == 4'd0) begin
            an_nx_s  = 4'b1111;
            seg_nx_s = 7'b1111111;
        end else begin
            an_nx_s  = 4'b1101;
            seg_nx_s = seg_encode(tens_s);
        end
    end

    // Free-running digit scan; seg and an load together only at slot boundaries.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scan_cnt_r <= '0;
            sel_r      <= 1'b0;
            seg_r      <= 7'b1000000;
            an_r       <= 4'b1110;
        end else if (scan_wrap_s) begin
            scan_cnt_r <= '0;
            sel_r      <= sel_nx_s;
            seg_r      <= seg_nx_s;
            an_r       <= an_nx_s;
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
            sel_r      <= sel_r;
            seg_r      <= seg_r;
            an_r       <= an_r;
        end
    end

    assign level       = level_r;
    assign level_valid = level_valid_r;
    assign led         = led_r;
    assign seg         = seg_r;
    assign an          = an_r;
    assign dp          = 1'b1;

endmodule

// File: tb/tb_audio_level_meter.sv
// Self-checking bench for audio_level_meter (WINDOW=8, SCAN_DIV=4, HOLD_WINDOWS=2).
// Table vectors, hand-written corner sequences, and random windows against a reference model.
module tb_audio_level_meter;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        sample_valid;
    logic [11:0] sample;
    logic [3:0]  level;
    logic        level_valid;
    logic [15:0] led;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int checks = 0;
    int errors = 0;
    int m_hold = 0;
    int m_timer = 0;

    typedef struct {
        int          fill;
        int          peak;
        int          pos;
        int          exp_level;
        logic [15:0] exp_led;
    } vec_t;

    vec_t tbl[6];

    audio_level_meter #(
        .WINDOW      (8),
        .SCAN_DIV    (4),
        .HOLD_WINDOWS(2)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .sample_valid(sample_valid),
        .sample      (sample),
        .level       (level),
        .level_valid (level_valid),
        .led         (led),
        .seg         (seg),
        .an          (an),
        .dp          (dp)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic int ref_level(input int peak);
        int l;
        if (peak <= 2048) return 0;
        l = (peak - 2048) / 128;
        return (l > 15) ? 15 : l;
    endfunction

    function automatic logic [15:0] therm(input int l);
        return 16'((1 << (l + 1)) - 1);
    endfunction

    task automatic model_window(input int lvl, output logic [15:0] exp_led);
`ifdef PEAK_HOLD_EN
        if (lvl >= m_hold) begin
            m_hold  = lvl;
            m_timer = 0;
        end else if (m_timer < 2) begin
            m_timer++;
        end else begin
            m_hold--;
        end
        exp_led = therm(lvl) | 16'(1 << m_hold);
`else
        exp_led = therm(lvl);
`endif
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        sample_valid = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        m_hold = 0;
        m_timer = 0;
    endtask

    // Called at a negedge; returns at the negedge after the sample was captured.
    task automatic strobe(input int v, input int closing, input string nm);
        sample = 12'(v);
        sample_valid = 1'b1;
        @(negedge CLK);
        sample_valid = 1'b0;
        check({nm, "_lv"}, int'(level_valid), closing);
    endtask

    task automatic run_window(input int fill, input int peak, input int pos, input string nm);
        for (int i = 0; i < 8; i++) begin
            strobe((i == pos) ? peak : fill, (i == 7) ? 1 : 0, nm);
        end
    endtask

    task automatic scan_check(input string nm, input logic [6:0] s0,
                              input logic [3:0] an1, input logic [6:0] s1);
        logic [3:0] prev;
        int found;
        int first0;
        int slot0;
        repeat (4) @(negedge CLK);
        prev = an;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge CLK);
            if (an != prev) found = 1;
        end
        check({nm, "_edge"}, found, 1);
        if (found == 1) begin
            first0 = (an == 4'b1110) ? 1 : 0;
            for (int k = 0; k < 16; k++) begin
                slot0 = ((((k / 4) % 2) == 0) == (first0 == 1)) ? 1 : 0;
                check({nm, "_an"}, int'(an), int'((slot0 == 1) ? 4'b1110 : an1));
                check({nm, "_seg"}, int'(seg), int'((slot0 == 1) ? s0 : s1));
                @(negedge CLK);
            end
        end
    endtask

    initial begin
        logic [15:0] exp_led;
        int          exp_hold[6];
        tbl[0] = '{fill: 2048, peak: 3000, pos: 3, exp_level: 7,  exp_led: 16'h00FF};
        tbl[1] = '{fill: 0,    peak: 1000, pos: 0, exp_level: 0,  exp_led: 16'h0001};
        tbl[2] = '{fill: 2048, peak: 2175, pos: 5, exp_level: 0,  exp_led: 16'h0001};
        tbl[3] = '{fill: 2048, peak: 2176, pos: 7, exp_level: 1,  exp_led: 16'h0003};
        tbl[4] = '{fill: 2048, peak: 4095, pos: 7, exp_level: 15, exp_led: 16'hFFFF};
        tbl[5] = '{fill: 100,  peak: 2304, pos: 2, exp_level: 2,  exp_led: 16'h0007};
        exp_hold = '{15, 15, 15, 14, 13, 12};

        RST_N = 1'b0;
        sample_valid = 1'b0;
        sample = 12'd0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Reset asserted mid-window and mid-scan
        for (int i = 0; i < 3; i++) strobe(4095, 0, "pre_rst");
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_level", int'(level), 0);
        check("rst_lv", int'(level_valid), 0);
        check("rst_led", int'(led), 16'h0001);
        check("rst_an", int'(an), 4'b1110);
        check("rst_seg", int'(seg), 7'b1000000);
        check("rst_dp", int'(dp), 1);
        @(negedge CLK);
        RST_N = 1'b1;

        // Table vectors, each from a clean reset
        for (int t = 0; t < 6; t++) begin
            do_reset();
            run_window(tbl[t].fill, tbl[t].peak, tbl[t].pos, "tbl");
            check("tbl_level", int'(level), tbl[t].exp_level);
            check("tbl_led", int'(led), int'(tbl[t].exp_led));
            @(negedge CLK);
            check("tbl_lv_drop", int'(level_valid), 0);
        end

        // Scan at level 15 and at level 3 (tens blank)
        do_reset();
        run_window(2048, 4095, 0, "scan15w");
        scan_check("scan15", 7'b0010010, 4'b1101, 7'b1111001);
        do_reset();
        run_window(2048, 2432, 4, "scan3w");
        check("scan3_level", int'(level), 3);
        scan_check("scan3", 7'b0110000, 4'b1111, 7'b1111111);

        // Reset mid-window discards a 4095 sample
        do_reset();
        strobe(4095, 0, "disc");
        strobe(2048, 0, "disc");
        strobe(2048, 0, "disc");
        do_reset();
        run_window(2100, 2100, 0, "disc_w");
        check("disc_level", int'(level), 0);
        check("disc_led", int'(led), 16'h0001);

`ifdef PEAK_HOLD_EN
        do_reset();
        for (int w = 0; w < 6; w++) begin
            run_window(2048, (w == 0) ? 4095 : 2304, 1, "hold_w");
            check("hold_level", int'(level), (w == 0) ? 15 : 2);
            check("hold_led", int'(led), int'(therm((w == 0) ? 15 : 2) | 16'(1 << exp_hold[w])));
            if (w == 3) scan_check("hold_scan14", 7'b0011001, 4'b1101, 7'b1111001);
        end
`endif

        // Random windows with idle gaps, against the reference model
        do_reset();
        for (int w = 0; w < 25; w++) begin
            int mx;
            int v;
            int mode;
            mx = 0;
            mode = int'($urandom_range(0, 2));
            for (int i = 0; i < 8; i++) begin
                case (mode)
                    0:       v = int'($urandom_range(0, 4095));
                    1:       v = int'($urandom_range(1900, 2600));
                    default: v = int'($urandom_range(2000, 2200));
                endcase
                if (v > mx) mx = v;
                strobe(v, (i == 7) ? 1 : 0, "rnd");
                if (i < 7 && $urandom_range(0, 2) == 0) @(negedge CLK);
            end
            model_window(ref_level(mx), exp_led);
            check("rnd_level", int'(level), ref_level(mx));
            check("rnd_led", int'(led), int'(exp_led));
        end
        @(negedge CLK);
        check("rnd_lv_drop", int'(level_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
